// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: shared widths, slave-select field, command encoding and round-robin helper.
package cross_bar_pkg;
    localparam int N_MASTERS = 4;
    localparam int N_SLAVES  = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int SEL_MSB   = 31;
    localparam int SEL_LSB   = 30;
    localparam int SEL_W     = SEL_MSB - SEL_LSB + 1;
    localparam int M_IDX_W   = $clog2(N_MASTERS);

    typedef logic [M_IDX_W-1:0] mid_t;
    typedef enum logic {CMD_READ = 1'b0, CMD_WRITE = 1'b1} cmd_e;

    // First requester at or after ptr, wrapping; scanning downward lets the nearest win.
    function automatic mid_t rr_pick(input logic [N_MASTERS-1:0] req, input mid_t ptr);
        mid_t idx;
        rr_pick = ptr;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            idx = ptr + mid_t'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/cross_bar_if.sv
// cross_bar_if: request/acknowledge bus between a master and a slave.
interface cross_bar_if;
    import cross_bar_pkg::*;
    logic              _req;
    logic [ADDR_W-1:0] _addr;
    logic              _cmd;
    logic [DATA_W-1:0] _wdata;
    logic              _ack;
    logic [DATA_W-1:0] _rdata;

    modport master (output _req, _addr, _cmd, _wdata, input _ack, _rdata);
    modport slave  (input _req, _addr, _cmd, _wdata, output _ack, _rdata);
endinterface

// File: rtl/cross_bar_rr_arbiter.sv
// rr_arbiter: per-slave round-robin arbiter; pointer advances past the winner only on ack.
module rr_arbiter
    import cross_bar_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 ack,
    output logic [N_MASTERS-1:0] gnt,
    output mid_t                 gnt_idx
);
    mid_t ptr;

    always_comb begin
        gnt_idx = rr_pick(req, ptr);
        gnt     = N_MASTERS'(|req) << gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (ack && |req) ptr <= gnt_idx + mid_t'(1);
    end
endmodule

// File: rtl/cross_bar.sv
// cross_bar: 4x4 request/ack crossbar with per-slave round-robin arbitration and 1-cycle read return.
module cross_bar
    import cross_bar_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    cross_bar_if.slave  master_0_if,
    cross_bar_if.slave  master_1_if,
    cross_bar_if.slave  master_2_if,
    cross_bar_if.slave  master_3_if,
    cross_bar_if.master slave_0_if,
    cross_bar_if.master slave_1_if,
    cross_bar_if.master slave_2_if,
    cross_bar_if.master slave_3_if
);
    logic [N_MASTERS-1:0] master_request;
    logic [N_MASTERS-1:0] requests_to_all_arbiters_from_all_masters [N_SLAVES-1:0];
    logic [ADDR_W-1:0]    m_addr  [N_MASTERS];
    logic [N_MASTERS-1:0] m_cmd;
    logic [DATA_W-1:0]    m_wdata [N_MASTERS];
    logic [N_MASTERS-1:0] m_ack;
    logic [DATA_W-1:0]    m_rdata [N_MASTERS];
    logic [N_SLAVES-1:0]  s_req, s_cmd, s_ack;
    logic [ADDR_W-1:0]    s_addr  [N_SLAVES];
    logic [DATA_W-1:0]    s_wdata [N_SLAVES];
    logic [DATA_W-1:0]    s_rdata [N_SLAVES];
    logic [N_MASTERS-1:0] gnt     [N_SLAVES];
    mid_t                 gnt_idx [N_SLAVES];
    logic [N_SLAVES-1:0]  pend_v;
    mid_t [N_SLAVES-1:0]  pend_id;

    assign master_request = {master_3_if._req, master_2_if._req, master_1_if._req, master_0_if._req};
    assign m_cmd   = {master_3_if._cmd, master_2_if._cmd, master_1_if._cmd, master_0_if._cmd};
    assign m_addr  = '{master_0_if._addr, master_1_if._addr, master_2_if._addr, master_3_if._addr};
    assign m_wdata = '{master_0_if._wdata, master_1_if._wdata, master_2_if._wdata, master_3_if._wdata};
    assign s_ack   = {slave_3_if._ack, slave_2_if._ack, slave_1_if._ack, slave_0_if._ack};
    assign s_rdata = '{slave_0_if._rdata, slave_1_if._rdata, slave_2_if._rdata, slave_3_if._rdata};

    assign master_0_if._ack = m_ack[0];
    assign master_1_if._ack = m_ack[1];
    assign master_2_if._ack = m_ack[2];
    assign master_3_if._ack = m_ack[3];
    assign master_0_if._rdata = m_rdata[0];
    assign master_1_if._rdata = m_rdata[1];
    assign master_2_if._rdata = m_rdata[2];
    assign master_3_if._rdata = m_rdata[3];

    assign slave_0_if._req = s_req[0];
    assign slave_1_if._req = s_req[1];
    assign slave_2_if._req = s_req[2];
    assign slave_3_if._req = s_req[3];
    assign slave_0_if._addr = s_addr[0];
    assign slave_1_if._addr = s_addr[1];
    assign slave_2_if._addr = s_addr[2];
    assign slave_3_if._addr = s_addr[3];
    assign slave_0_if._cmd = s_cmd[0];
    assign slave_1_if._cmd = s_cmd[1];
    assign slave_2_if._cmd = s_cmd[2];
    assign slave_3_if._cmd = s_cmd[3];
    assign slave_0_if._wdata = s_wdata[0];
    assign slave_1_if._wdata = s_wdata[1];
    assign slave_2_if._wdata = s_wdata[2];
    assign slave_3_if._wdata = s_wdata[3];

    for (genvar s = 0; s < N_SLAVES; s++) begin : g_slave
        for (genvar m = 0; m < N_MASTERS; m++) begin : g_req
            assign requests_to_all_arbiters_from_all_masters[s][m] =
                master_request[m] && m_addr[m][SEL_MSB:SEL_LSB] == SEL_W'(s);
        end
        rr_arbiter u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (requests_to_all_arbiters_from_all_masters[s]),
            .ack     (s_ack[s]),
            .gnt     (gnt[s]),
            .gnt_idx (gnt_idx[s])
        );
        assign s_req[s]   = |gnt[s];
        assign s_addr[s]  = s_req[s] ? m_addr[gnt_idx[s]]  : '0;
        assign s_cmd[s]   = s_req[s] ? m_cmd[gnt_idx[s]]   : 1'b0;
        assign s_wdata[s] = s_req[s] ? m_wdata[gnt_idx[s]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v  <= '0;
            pend_id <= '0;
        end else begin
            for (int s = 0; s < N_SLAVES; s++) begin
                pend_v[s]  <= s_req[s] && s_ack[s] && s_cmd[s] == CMD_READ;
                pend_id[s] <= gnt_idx[s];
            end
        end
    end

    // A master has at most one request in flight, so at most one slave term is non-zero per master.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            m_ack[m]   = 1'b0;
            m_rdata[m] = '0;
            for (int s = 0; s < N_SLAVES; s++) begin
                m_ack[m]   = m_ack[m] | (s_req[s] && s_ack[s] && gnt_idx[s] == mid_t'(m));
                m_rdata[m] = m_rdata[m] | ((pend_v[s] && pend_id[s] == mid_t'(m)) ? s_rdata[s] : '0);
            end
        end
    end
endmodule

// File: tb/tb_cross_bar.sv
// tb_cross_bar: scoreboard bench for cross_bar routing, round-robin order and read return.
module tb_cross_bar;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  m_req = '0, m_cmd = '0, s_ack = '0;
    logic [31:0] m_addr [4];
    logic [31:0] m_wdata [4];
    logic [31:0] s_rdata [4];
    wire  [3:0]  m_ack, s_req, s_cmd;
    wire  [31:0] m_rdata [4];
    wire  [31:0] s_addr [4];
    wire  [31:0] s_wdata [4];

    cross_bar_if mi [4] ();
    cross_bar_if si [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_conn
        assign mi[g]._req   = m_req[g];
        assign mi[g]._addr  = m_addr[g];
        assign mi[g]._cmd   = m_cmd[g];
        assign mi[g]._wdata = m_wdata[g];
        assign m_ack[g]     = mi[g]._ack;
        assign m_rdata[g]   = mi[g]._rdata;
        assign si[g]._ack   = s_ack[g];
        assign si[g]._rdata = s_rdata[g];
        assign s_req[g]     = si[g]._req;
        assign s_addr[g]    = si[g]._addr;
        assign s_cmd[g]     = si[g]._cmd;
        assign s_wdata[g]   = si[g]._wdata;
    end

    cross_bar dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .master_0_if (mi[0]),
        .master_1_if (mi[1]),
        .master_2_if (mi[2]),
        .master_3_if (mi[3]),
        .slave_0_if  (si[0]),
        .slave_1_if  (si[1]),
        .slave_2_if  (si[2]),
        .slave_3_if  (si[3])
    );

    typedef struct {
        int          due;
        int          m;
        logic [31:0] data;
    } rd_t;

    rd_t rd_q [$];
    int  gnt_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every master's rdata must equal the scoreboard entry due this cycle, or zero.
    task automatic check_reads();
        logic [31:0] exp [4];
        for (int m = 0; m < 4; m++) exp[m] = '0;
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            rd_t e = rd_q.pop_front();
            exp[e.m] = e.data;
        end
        for (int m = 0; m < 4; m++) check($sformatf("rdata_m%0d", m), m_rdata[m], exp[m]);
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_reads();
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_req = '0;
        m_cmd = '0;
        s_ack = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0;
            m_wdata[i] = '0;
            s_rdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        at_neg();
        check("rst_ack", {28'd0, m_ack}, 32'd0);
        rst_n = 1'b1;

        // single write m0 -> s1
        drive_edge();
        m_req[0] = 1'b1; m_addr[0] = 32'h4000_0000; m_cmd[0] = 1'b1; m_wdata[0] = 32'd5;
        at_neg();
        check("mreq0", {31'd0, dut.master_request[0]}, 32'd1);
        check("mreq3", {31'd0, dut.master_request[3]}, 32'd0);
        check("arb_req1", {28'd0, dut.requests_to_all_arbiters_from_all_masters[1]}, 32'd1);
        check("arb_req0", {28'd0, dut.requests_to_all_arbiters_from_all_masters[0]}, 32'd0);
        check("s1_req", {28'd0, s_req}, 32'b0010);
        check("s1_wdata", s_wdata[1], 32'd5);
        check("s1_addr", s_addr[1], 32'h4000_0000);
        check("s0_wdata_idle", s_wdata[0], 32'd0);
        s_ack[1] = 1'b1;
        #1 check("w_ack", {28'd0, m_ack}, 32'b0001);

        // read m2 -> s3, data returns one cycle after ack
        drive_edge();
        idle();
        m_req[2] = 1'b1; m_addr[2] = 32'hC000_0010; m_cmd[2] = 1'b0; s_ack[3] = 1'b1;
        rd_q.push_back('{cyc + 1, 2, 32'hDEAD_BEEF});
        at_neg();
        check("r_ack", {28'd0, m_ack}, 32'b0100);
        check("s3_cmd", {31'd0, s_cmd[3]}, 32'd0);
        drive_edge();
        idle();
        s_rdata[3] = 32'hDEAD_BEEF;
        at_neg();
        drive_edge();
        at_neg();

        // four masters contend for s2 with an ack every cycle
        gnt_q = '{0, 1, 2, 3, 0};
        drive_edge();
        s_rdata[3] = '0;
        for (int m = 0; m < 4; m++) begin
            m_req[m] = 1'b1; m_addr[m] = 32'h8000_0000 + 32'(m * 4); m_cmd[m] = 1'b0;
        end
        s_ack[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int exp_m;
            if (i > 0) drive_edge();
            s_rdata[2] = 32'h2000_0000 + 32'(cyc);
            exp_m = gnt_q.pop_front();
            at_neg();
            check($sformatf("rr_ack%0d", i), {28'd0, m_ack}, 32'd1 << exp_m);
            check($sformatf("rr_addr%0d", i), s_addr[2], 32'h8000_0000 + 32'(exp_m * 4));
            rd_q.push_back('{cyc + 1, exp_m, 32'h2000_0000 + 32'(cyc + 1)});
        end
        drive_edge();
        idle();
        s_rdata[2] = 32'h2000_0000 + 32'(cyc);
        at_neg();

        // four disjoint transfers in one cycle
        drive_edge();
        for (int m = 0; m < 4; m++) begin
            m_req[m] = 1'b1; m_cmd[m] = 1'b0;
            m_addr[m] = {2'(3 - m), 30'(m * 4)};
        end
        s_ack = 4'hF;
        at_neg();
        check("par_ack", {28'd0, m_ack}, 32'hF);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("par_addr_s%0d", 3 - m), s_addr[3 - m], {2'(3 - m), 30'(m * 4)});
            rd_q.push_back('{cyc + 1, m, 32'hA0 + 32'(3 - m)});
        end
        drive_edge();
        idle();
        for (int s = 0; s < 4; s++) s_rdata[s] = 32'hA0 + 32'(s);
        at_neg();

        // withheld ack keeps grant on m0; after its ack m1 wins even with m0 still asking
        drive_edge();
        for (int s = 0; s < 4; s++) s_rdata[s] = '0;
        m_req[1:0] = 2'b11; m_cmd[1:0] = 2'b11;
        m_addr[0] = 32'h0000_0100; m_wdata[0] = 32'h11;
        m_addr[1] = 32'h0000_0200; m_wdata[1] = 32'h22;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) drive_edge();
            at_neg();
            check($sformatf("hold_addr%0d", i), s_addr[0], 32'h0000_0100);
            check($sformatf("hold_ack%0d", i), {28'd0, m_ack}, 32'd0);
        end
        drive_edge();
        s_ack[0] = 1'b1;
        at_neg();
        check("hold_wdata", s_wdata[0], 32'h11);
        check("hold_ack_m0", {28'd0, m_ack}, 32'b0001);
        drive_edge();
        s_ack[0] = 1'b0;
        at_neg();
        check("next_addr", s_addr[0], 32'h0000_0200);
        s_ack[0] = 1'b1;
        #1 check("next_ack_m1", {28'd0, m_ack}, 32'b0010);

        // reset during a pending read discards it
        drive_edge();
        idle();
        m_req[1] = 1'b1; m_cmd[1] = 1'b0; m_addr[1] = 32'h0000_0040; s_ack[0] = 1'b1;
        at_neg();
        check("pre_rst_ack", {28'd0, m_ack}, 32'b0010);
        drive_edge();
        check("pend_set", {28'd0, dut.pend_v}, 32'b0001);
        rst_n = 1'b0;
        idle();
        s_rdata[0] = 32'h0000_0BAD;
        #1 check("pend_clr", {28'd0, dut.pend_v}, 32'd0);
        at_neg();
        drive_edge();
        rst_n = 1'b1;
        at_neg();

        if (rd_q.size() != 0) check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
